// File: rtl/control_timer.sv
// Timer-path sequencer: edit-mode control, preset latch and 1 Hz BCD countdown
// with expiry flag and acknowledge-driven reload.
module control_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       boton_prog,
    input  logic       boton_start,
    input  logic       boton_l,
    input  logic       boton_r,
    input  logic       tick_1hz,
    input  logic [7:0] segundos_in,
    input  logic [7:0] minutos_in,
    input  logic [7:0] horas_in,
    output logic       cambiar_timer,
    output logic [1:0] pos_x,
    output logic [7:0] segundosT,
    output logic [7:0] minutosT,
    output logic [7:0] horasT,
    output logic       timer_fin,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EDIT  = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] pos_q, pos_d;
    logic [7:0] preS_q, preS_d, preM_q, preM_d, preH_q, preH_d;
    logic [7:0] cntS_q, cntS_d, cntM_q, cntM_d, cntH_q, cntH_d;
    logic [3:0] btn_q;
    logic       editFlag_q, finFlag_q;
    logic       progE, startE, lE, rE;
    logic       presetZero, lastSecond;
    logic [8:0] decS, decM, decH;

    // Borrow-out in bit 8; a zero pair wraps to the given value.
    function automatic logic [8:0] decPair(input logic [7:0] v, input logic [7:0] wrap);
        if (v == 8'h00)
            decPair = {1'b1, wrap};
        else if (v[3:0] == 4'h0)
            decPair = {1'b0, v[7:4] - 4'd1, 4'h9};
        else
            decPair = {1'b0, v - 8'd1};
    endfunction

    assign progE  = boton_prog  & ~btn_q[3];
    assign startE = boton_start & ~btn_q[2];
    assign lE     = boton_l     & ~btn_q[1];
    assign rE     = boton_r     & ~btn_q[0];

    assign presetZero = (preS_q == 8'h00) && (preM_q == 8'h00) && (preH_q == 8'h00);
    assign lastSecond = (cntS_q == 8'h01) && (cntM_q == 8'h00) && (cntH_q == 8'h00);

    assign decS = decPair(cntS_q, 8'h59);
    assign decM = decS[8] ? decPair(cntM_q, 8'h59) : {1'b0, cntM_q};
    assign decH = decM[8] ? decPair(cntH_q, 8'h00) : {1'b0, cntH_q};

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        preS_d  = preS_q;
        preM_d  = preM_q;
        preH_d  = preH_q;
        cntS_d  = cntS_q;
        cntM_d  = cntM_q;
        cntH_d  = cntH_q;
        case (state_q)
            IDLE: begin
                if (progE)
                    state_d = EDIT;
                else if (startE && !presetZero)
                    state_d = RUN;
            end
            EDIT: begin
                if (progE) begin
                    state_d = IDLE;
                    preS_d  = segundos_in;
                    preM_d  = minutos_in;
                    preH_d  = horas_in;
                    cntS_d  = segundos_in;
                    cntM_d  = minutos_in;
                    cntH_d  = horas_in;
                end else if (lE && !rE) begin
                    pos_d = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
                end else if (rE && !lE) begin
                    pos_d = (pos_q == 2'd0) ? 2'd2 : pos_q - 2'd1;
                end
            end
            RUN: begin
                if (progE) begin
                    state_d = IDLE;
                    cntS_d  = preS_q;
                    cntM_d  = preM_q;
                    cntH_d  = preH_q;
                end else if (startE) begin
                    state_d = PAUSE;
                end else if (tick_1hz) begin
                    cntS_d = decS[7:0];
                    cntM_d = decM[7:0];
                    cntH_d = decH[7:0];
                    if (lastSecond)
                        state_d = DONE;
                end
            end
            PAUSE: begin
                if (progE) begin
                    state_d = IDLE;
                    cntS_d  = preS_q;
                    cntM_d  = preM_q;
                    cntH_d  = preH_q;
                end else if (startE) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (progE || startE) begin
                    state_d = IDLE;
                    cntS_d  = preS_q;
                    cntM_d  = preM_q;
                    cntH_d  = preH_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buttons preload high in reset so a level held through release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pos_q      <= 2'd0;
            preS_q     <= 8'h00;
            preM_q     <= 8'h00;
            preH_q     <= 8'h00;
            cntS_q     <= 8'h00;
            cntM_q     <= 8'h00;
            cntH_q     <= 8'h00;
            btn_q      <= 4'b1111;
            editFlag_q <= 1'b0;
            finFlag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            preS_q     <= preS_d;
            preM_q     <= preM_d;
            preH_q     <= preH_d;
            cntS_q     <= cntS_d;
            cntM_q     <= cntM_d;
            cntH_q     <= cntH_d;
            btn_q      <= {boton_prog, boton_start, boton_l, boton_r};
            editFlag_q <= (state_d == EDIT);
            finFlag_q  <= (state_d == DONE);
        end
    end

    assign cambiar_timer = editFlag_q;
    assign timer_fin     = finFlag_q;
    assign pos_x         = pos_q;
    assign segundosT     = cntS_q;
    assign minutosT      = cntM_q;
    assign horasT        = cntH_q;
    assign estado        = state_q;

endmodule

// File: tb/tb_control_timer.sv
// Self-checking bench for control_timer: directed scenarios followed by random
// button/tick traffic, compared every cycle against a seconds-based reference model.
module tb_control_timer;

    logic       clk = 1'b0;
    logic       reset, boton_prog, boton_start, boton_l, boton_r, tick_1hz;
    logic [7:0] segundos_in, minutos_in, horas_in;
    logic       cambiar_timer, timer_fin;
    logic [1:0] pos_x;
    logic [7:0] segundosT, minutosT, horasT;
    logic [2:0] estado;

    int checks = 0;
    int errors = 0;

    // Reference model: state code, pointer, and preset/count as total seconds
    int mState, mPos, mPre, mCnt;
    bit pProg, pStart, pL, pR;

    control_timer dut (
        .clk(clk), .reset(reset),
        .boton_prog(boton_prog), .boton_start(boton_start),
        .boton_l(boton_l), .boton_r(boton_r), .tick_1hz(tick_1hz),
        .segundos_in(segundos_in), .minutos_in(minutos_in), .horas_in(horas_in),
        .cambiar_timer(cambiar_timer), .pos_x(pos_x),
        .segundosT(segundosT), .minutosT(minutosT), .horasT(horasT),
        .timer_fin(timer_fin), .estado(estado)
    );

    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model
    task automatic checkOutput();
        chk("estado", {5'd0, estado}, 8'(mState));
        chk("pos_x", {6'd0, pos_x}, 8'(mPos));
        chk("cambiar_timer", {7'd0, cambiar_timer}, {7'd0, mState == 1});
        chk("timer_fin", {7'd0, timer_fin}, {7'd0, mState == 4});
        chk("segundosT", segundosT, int2bcd(mCnt % 60));
        chk("minutosT", minutosT, int2bcd((mCnt / 60) % 60));
        chk("horasT", horasT, int2bcd(mCnt / 3600));
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge
    task automatic applyStimulus(input bit rst, input bit p, input bit s,
                                 input bit l, input bit r, input bit t);
        bit pe, se, le, re;
        reset = rst; boton_prog = p; boton_start = s;
        boton_l = l; boton_r = r; tick_1hz = t;
        if (rst) begin
            mState = 0; mPos = 0; mPre = 0; mCnt = 0;
            pProg = 1; pStart = 1; pL = 1; pR = 1;
        end else begin
            pe = p & ~pProg; se = s & ~pStart; le = l & ~pL; re = r & ~pR;
            case (mState)
                0: if (pe) mState = 1; else if (se && mPre != 0) mState = 2;
                1: begin
                    if (pe) begin
                        mState = 0;
                        mPre = bcd2int(horas_in) * 3600 + bcd2int(minutos_in) * 60
                               + bcd2int(segundos_in);
                        mCnt = mPre;
                    end else if (le && !re) mPos = (mPos + 1) % 3;
                    else if (re && !le) mPos = (mPos + 2) % 3;
                end
                2: begin
                    if (pe) begin mState = 0; mCnt = mPre; end
                    else if (se) mState = 3;
                    else if (t) begin
                        mCnt = mCnt - 1;
                        if (mCnt == 0) mState = 4;
                    end
                end
                3: begin
                    if (pe) begin mState = 0; mCnt = mPre; end
                    else if (se) mState = 2;
                end
                default: if (pe || se) begin mState = 0; mCnt = mPre; end
            endcase
            pProg = p; pStart = s; pL = l; pR = r;
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle();      applyStimulus(0, 0, 0, 0, 0, 0); endtask
    task automatic pressProg(); applyStimulus(0, 1, 0, 0, 0, 0); idle(); endtask
    task automatic pressStart();applyStimulus(0, 0, 1, 0, 0, 0); idle(); endtask
    task automatic pressL();    applyStimulus(0, 0, 0, 1, 0, 0); idle(); endtask
    task automatic pressR();    applyStimulus(0, 0, 0, 0, 1, 0); idle(); endtask
    task automatic tick();      applyStimulus(0, 0, 0, 0, 0, 1); endtask

    task automatic loadPreset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        pressProg();
        horas_in = h; minutos_in = m; segundos_in = s;
        pressProg();
    endtask

    task automatic expectCount(input string tag, input logic [7:0] h,
                               input logic [7:0] m, input logic [7:0] s);
        chk({tag, "_h"}, horasT, h);
        chk({tag, "_m"}, minutosT, m);
        chk({tag, "_s"}, segundosT, s);
    endtask

    initial begin
        horas_in = 8'h00; minutos_in = 8'h00; segundos_in = 8'h00;

        // Reset with start held through release: no event until re-pressed
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        chk("rst_estado", {5'd0, estado}, 8'h00);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        chk("held_start_estado", {5'd0, estado}, 8'h00);
        idle();
        pressStart();
        chk("zero_preset_start", {5'd0, estado}, 8'h00);

        // Pointer walk and commit of 01:02:30
        pressProg();
        chk("edit_cambiar", {7'd0, cambiar_timer}, 8'h01);
        pressL(); chk("pos_l1", {6'd0, pos_x}, 8'd1);
        pressL(); chk("pos_l2", {6'd0, pos_x}, 8'd2);
        pressL(); chk("pos_l3", {6'd0, pos_x}, 8'd0);
        pressR(); chk("pos_r", {6'd0, pos_x}, 8'd2);
        applyStimulus(0, 0, 0, 1, 1, 0); idle();
        chk("pos_lr", {6'd0, pos_x}, 8'd2);
        horas_in = 8'h01; minutos_in = 8'h02; segundos_in = 8'h30;
        pressProg();
        expectCount("commit", 8'h01, 8'h02, 8'h30);
        chk("commit_cambiar", {7'd0, cambiar_timer}, 8'h00);

        // Borrow across hours/minutes/seconds
        loadPreset(8'h01, 8'h00, 8'h00);
        pressStart();
        tick(); expectCount("borrow1", 8'h00, 8'h59, 8'h59);
        tick(); expectCount("borrow2", 8'h00, 8'h59, 8'h58);
        pressProg();

        // Expiry, ticks ignored in DONE, acknowledge reloads
        loadPreset(8'h00, 8'h00, 8'h02);
        pressStart();
        tick(); tick();
        chk("done_estado", {5'd0, estado}, 8'd4);
        chk("done_fin", {7'd0, timer_fin}, 8'h01);
        tick(); idle();
        expectCount("done_hold", 8'h00, 8'h00, 8'h00);
        pressStart();
        expectCount("ack_reload", 8'h00, 8'h00, 8'h02);
        chk("ack_fin", {7'd0, timer_fin}, 8'h00);

        // Start and tick together pause without decrementing
        loadPreset(8'h00, 8'h00, 8'h10);
        pressStart();
        applyStimulus(0, 0, 1, 0, 0, 1);
        chk("pause_estado", {5'd0, estado}, 8'd3);
        expectCount("pause_hold", 8'h00, 8'h00, 8'h10);
        idle(); tick();
        expectCount("pause_tick", 8'h00, 8'h00, 8'h10);
        pressStart(); tick();
        expectCount("resume_tick", 8'h00, 8'h00, 8'h09);
        // Prog beats start in the same cycle
        applyStimulus(0, 1, 1, 0, 0, 0); idle();
        chk("prog_wins", {5'd0, estado}, 8'd0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                horas_in = 8'h00; minutos_in = 8'h00;
                segundos_in = int2bcd($urandom_range(0, 8));
            end else begin
                horas_in = int2bcd($urandom_range(0, 23));
                minutos_in = int2bcd($urandom_range(0, 59));
                segundos_in = int2bcd($urandom_range(0, 59));
            end
            applyStimulus($urandom_range(0, 599) == 0,
                          $urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                          $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
